// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / interrupt controller.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 4;

    // Instruction word substituted for a flushed fetch slot.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Controller FSM encoding.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_IRQ_WAIT = 2'd1,
        ST_IRQ_INJ  = 2'd2,
        ST_IRQ_SVC  = 2'd3
    } ctrl_state_e;

    // Hazard sources ranked by priority: a lower code wins.
    typedef enum logic [2:0] {
        HZ_MEM_WAIT   = 3'd0,
        HZ_SEND       = 3'd1,
        HZ_MISPREDICT = 3'd2,
        HZ_LOAD_USE   = 3'd3,
        HZ_IRQ_INJ    = 3'd4,
        HZ_NONE       = 3'd7
    } hazard_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side status in, stall/flush/interrupt control out.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
);
    logic [REG_ADDR_W-1:0]  id_p0_addr;
    logic [REG_ADDR_W-1:0]  id_p1_addr;
    logic                   id_p0_used;
    logic                   id_p1_used;
    logic                   ex_mem_re;
    logic [REG_ADDR_W-1:0]  ex_dst_addr;
    logic                   mispredict;
    logic                   send_pending;
    logic                   spart_full;
    logic                   mem_wait;
    logic                   irq;
    logic                   irq_done;

    logic                   stall_if;
    logic                   flush_if;
    logic                   stall_id;
    logic                   flush_id;
    logic                   stall_ex;
    logic                   store_current;
    logic                   irq_ack;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Pipeline side: reports stage status, obeys control.
    modport master (
        output id_p0_addr, id_p1_addr, id_p0_used, id_p1_used,
               ex_mem_re, ex_dst_addr, mispredict, send_pending,
               spart_full, mem_wait, irq, irq_done,
        input  stall_if, flush_if, stall_id, flush_id, stall_ex,
               store_current, irq_ack, stall_cnt
    );

    // Controller side.
    modport slave (
        input  id_p0_addr, id_p1_addr, id_p0_used, id_p1_used,
               ex_mem_re, ex_dst_addr, mispredict, send_pending,
               spart_full, mem_wait, irq, irq_done,
        output stall_if, flush_if, stall_id, flush_id, stall_ex,
               store_current, irq_ack, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: decode reads the register a load in execute writes.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_p0_addr,
    input  logic [REG_ADDR_W-1:0] id_p1_addr,
    input  logic                  id_p0_used,
    input  logic                  id_p1_used,
    input  logic                  ex_mem_re,
    input  logic [REG_ADDR_W-1:0] ex_dst_addr,
    output logic                  load_use
);

    // r0 is hard-wired, so a load targeting it never creates a dependency.
    always_comb begin
        load_use = ex_mem_re && (ex_dst_addr != '0) &&
                   ((id_p0_used && (id_p0_addr == ex_dst_addr)) ||
                    (id_p1_used && (id_p1_addr == ex_dst_addr)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller with interrupt injection and stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input logic        clk,
    input logic        rst_n,
    pipe_ctrl_if.slave bus
);

    ctrl_state_e            state_q, state_d;
    logic                   lu_done_q, lu_done_d;
    logic                   irq_ack_q, irq_ack_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic    lu_raw;
    logic    lu_eff;
    hazard_e hz;
    logic    stall_if_c, flush_if_c, stall_id_c, flush_id_c, stall_ex_c, store_c;
    logic    stall_if_o;

    hazard_detect u_hazard_detect (
        .id_p0_addr  (bus.id_p0_addr),
        .id_p1_addr  (bus.id_p1_addr),
        .id_p0_used  (bus.id_p0_used),
        .id_p1_used  (bus.id_p1_used),
        .ex_mem_re   (bus.ex_mem_re),
        .ex_dst_addr (bus.ex_dst_addr),
        .load_use    (lu_raw)
    );

    // Pick the single winning hazard; a load-use already serviced last cycle is masked.
    always_comb begin
        lu_eff = lu_raw && !lu_done_q;
        hz     = HZ_NONE;
        if (bus.mem_wait)                              hz = HZ_MEM_WAIT;
        else if (bus.send_pending && bus.spart_full)   hz = HZ_SEND;
        else if (bus.mispredict)                       hz = HZ_MISPREDICT;
        else if (lu_eff)                               hz = HZ_LOAD_USE;
        else if (state_q == ST_IRQ_INJ)                hz = HZ_IRQ_INJ;
    end

    // Control outputs for the winning hazard and interrupt FSM next state.
    always_comb begin
        state_d    = state_q;
        stall_if_c = 1'b0;
        flush_if_c = 1'b0;
        stall_id_c = 1'b0;
        flush_id_c = 1'b0;
        stall_ex_c = 1'b0;
        store_c    = 1'b0;
        irq_ack_d  = 1'b0;
        lu_done_d  = 1'b0;

        case (hz)
            HZ_MEM_WAIT: begin
                stall_if_c = 1'b1;
                stall_id_c = 1'b1;
                stall_ex_c = 1'b1;
            end
            HZ_SEND: begin
                stall_if_c = 1'b1;
                stall_id_c = 1'b1;
            end
            HZ_MISPREDICT: begin
                flush_if_c = 1'b1;
                flush_id_c = 1'b1;
            end
            HZ_LOAD_USE: begin
                stall_if_c = 1'b1;
                flush_id_c = 1'b1;
                lu_done_d  = 1'b1;
            end
            HZ_IRQ_INJ: begin
                store_c    = 1'b1;
                flush_if_c = 1'b1;
                irq_ack_d  = 1'b1;
            end
            default: ;
        endcase

        case (state_q)
            ST_RUN:      if (bus.irq) state_d = ST_IRQ_WAIT;
            ST_IRQ_WAIT: begin
                if (!bus.irq)          state_d = ST_RUN;
                else if (hz == HZ_NONE) state_d = ST_IRQ_INJ;
            end
            // A pre-empted injection goes back to waiting for a clean cycle.
            ST_IRQ_INJ:  state_d = (hz == HZ_IRQ_INJ) ? ST_IRQ_SVC : ST_IRQ_WAIT;
            ST_IRQ_SVC:  if (bus.irq_done) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    // Saturating count of fetch-stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if_o && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    // State, acknowledge, load-use mask and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            lu_done_q   <= 1'b0;
            irq_ack_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_done_q   <= lu_done_d;
            irq_ack_q   <= irq_ack_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Control outputs are forced quiet while reset is held, whatever the inputs.
    assign stall_if_o        = rst_n & stall_if_c;
    assign bus.stall_if      = stall_if_o;
    assign bus.flush_if      = rst_n & flush_if_c;
    assign bus.stall_id      = rst_n & stall_id_c;
    assign bus.flush_id      = rst_n & flush_id_c;
    assign bus.stall_ex      = rst_n & stall_ex_c;
    assign bus.store_current = rst_n & store_c;
    assign bus.irq_ack       = irq_ack_q;
    assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expectations queued at drive time, checked at negedge.
module tb_pipe_ctrl;

    localparam int CW = 4;

    // {stall_if, flush_if, stall_id, flush_id, stall_ex, store_current, irq_ack}
    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_MEM  = 7'b1010100;
    localparam logic [6:0] E_SEND = 7'b1010000;
    localparam logic [6:0] E_MISP = 7'b0101000;
    localparam logic [6:0] E_LU   = 7'b1001000;
    localparam logic [6:0] E_INJ  = 7'b0100010;
    localparam logic [6:0] E_ACK  = 7'b0000001;

    typedef struct packed {
        logic [6:0]    ctl;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    pipe_ctrl_if #(.STALL_CNT_W(CW)) bus ();

    pipe_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t          exp_q[$];
    string         tag_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [CW-1:0] model_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clr_in();
        bus.id_p0_addr   = 4'd0;
        bus.id_p1_addr   = 4'd0;
        bus.id_p0_used   = 1'b0;
        bus.id_p1_used   = 1'b0;
        bus.ex_mem_re    = 1'b0;
        bus.ex_dst_addr  = 4'd0;
        bus.mispredict   = 1'b0;
        bus.send_pending = 1'b0;
        bus.spart_full   = 1'b0;
        bus.mem_wait     = 1'b0;
        bus.irq          = 1'b0;
        bus.irq_done     = 1'b0;
    endtask

    task automatic set_lu(input logic [3:0] dst, input logic [3:0] src, input logic on_p1);
        bus.ex_mem_re   = 1'b1;
        bus.ex_dst_addr = dst;
        if (on_p1) begin
            bus.id_p1_addr = src;
            bus.id_p1_used = 1'b1;
        end else begin
            bus.id_p0_addr = src;
            bus.id_p0_used = 1'b1;
        end
    endtask

    // Queue this cycle's expectation, advance the counter model, then move to the next cycle.
    task automatic cyc(input string tag, input logic [6:0] ctl);
        exp_t e;
        if (!rst_n) model_cnt = '0;
        e.ctl = ctl;
        e.cnt = model_cnt;
        if (rst_n && ctl[6] && (model_cnt != {CW{1'b1}})) model_cnt = model_cnt + 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".ctl"}, 32'({bus.stall_if, bus.flush_if, bus.stall_id, bus.flush_id,
                                  bus.stall_ex, bus.store_current, bus.irq_ack}), 32'(e.ctl));
            chk({t, ".cnt"}, 32'(bus.stall_cnt), 32'(e.cnt));
        end
    end

    initial begin
        rst_n = 1'b0;
        clr_in();
        @(posedge clk);
        #1;

        // Reset dominates live hazard and interrupt inputs.
        bus.mem_wait = 1'b1; bus.mispredict = 1'b1; bus.irq = 1'b1;
        set_lu(4'd3, 4'd3, 1'b1);
        cyc("rst0", E_NONE);
        cyc("rst1", E_NONE);
        rst_n = 1'b1;
        clr_in();
        cyc("idle", E_NONE);

        // Load-use on p1 for r3: one cycle only, then r0 never stalls.
        set_lu(4'd3, 4'd3, 1'b1);
        cyc("lu_r3", E_LU);
        cyc("lu_r3_held", E_NONE);
        clr_in();
        cyc("lu_gap", E_NONE);
        set_lu(4'd0, 4'd0, 1'b1);
        cyc("lu_r0", E_NONE);
        clr_in();
        set_lu(4'd5, 4'd5, 1'b0);
        bus.id_p0_used = 1'b0;
        cyc("lu_unused", E_NONE);
        bus.id_p0_used = 1'b1;
        cyc("lu_p0", E_LU);
        clr_in();
        cyc("gap1", E_NONE);

        // mem_wait masks a pending load-use for three cycles.
        set_lu(4'd7, 4'd7, 1'b0);
        bus.mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) cyc("mw_lu", E_MEM);
        bus.mem_wait = 1'b0;
        cyc("mw_then_lu", E_LU);
        clr_in();
        cyc("gap2", E_NONE);

        // Priority between send block, mem_wait and mispredict.
        bus.send_pending = 1'b1;
        cyc("send_only", E_NONE);
        bus.spart_full = 1'b1;
        cyc("send_blk", E_SEND);
        bus.mem_wait = 1'b1;
        cyc("send_mw", E_MEM);
        bus.mem_wait = 1'b0; bus.mispredict = 1'b1;
        cyc("send_misp", E_SEND);
        bus.send_pending = 1'b0;
        cyc("misp", E_MISP);
        set_lu(4'd9, 4'd9, 1'b1);
        cyc("misp_lu", E_MISP);
        clr_in();
        cyc("gap3", E_NONE);

        // irq held back by a four-cycle send block.
        bus.irq = 1'b1; bus.send_pending = 1'b1; bus.spart_full = 1'b1;
        for (int i = 0; i < 4; i++) cyc("irq_blk", E_SEND);
        bus.send_pending = 1'b0; bus.spart_full = 1'b0;
        cyc("irq_clean", E_NONE);
        cyc("irq_inj", E_INJ);
        cyc("irq_ack", E_ACK);
        cyc("svc_irq_hi", E_NONE);
        bus.irq_done = 1'b1;
        cyc("svc_done", E_NONE);
        clr_in();
        cyc("run", E_NONE);

        // irq_done outside service has no effect on the sequence.
        bus.irq = 1'b1; bus.irq_done = 1'b1;
        cyc("done_run", E_NONE);
        cyc("done_wait", E_NONE);
        bus.irq_done = 1'b0;
        cyc("done_inj", E_INJ);
        cyc("done_ack", E_ACK);
        bus.irq = 1'b0;
        cyc("svc_lo", E_NONE);
        bus.irq_done = 1'b1;
        cyc("svc_done2", E_NONE);
        clr_in();
        cyc("run2", E_NONE);

        // irq withdrawn while waiting: no injection.
        bus.irq = 1'b1;
        cyc("wd_run", E_NONE);
        bus.irq = 1'b0;
        cyc("wd_wait", E_NONE);
        cyc("wd_none", E_NONE);
        cyc("wd_none2", E_NONE);

        // mispredict pre-empts the injection cycle; retry on the next clean cycle.
        bus.irq = 1'b1;
        cyc("pre_run", E_NONE);
        cyc("pre_wait", E_NONE);
        bus.mispredict = 1'b1;
        cyc("pre_inj_misp", E_MISP);
        bus.mispredict = 1'b0;
        cyc("pre_rewait", E_NONE);
        cyc("pre_inj", E_INJ);
        bus.irq = 1'b0; bus.irq_done = 1'b1;
        cyc("pre_ack", E_ACK);
        clr_in();
        cyc("pre_run2", E_NONE);

        // Counter saturation.
        bus.mem_wait = 1'b1;
        for (int i = 0; i < (1 << CW) + 5; i++) cyc("sat", E_MEM);
        clr_in();
        cyc("sat_hold", E_NONE);

        // Reset during service with irq high restarts from RUN.
        bus.irq = 1'b1;
        cyc("r_run", E_NONE);
        cyc("r_wait", E_NONE);
        cyc("r_inj", E_INJ);
        cyc("r_ack", E_ACK);
        rst_n = 1'b0; bus.mem_wait = 1'b1;
        cyc("r_rst0", E_NONE);
        cyc("r_rst1", E_NONE);
        rst_n = 1'b1; bus.mem_wait = 1'b0;
        cyc("r2_run", E_NONE);
        cyc("r2_wait", E_NONE);
        cyc("r2_inj", E_INJ);
        bus.irq = 1'b0; bus.irq_done = 1'b1;
        cyc("r2_ack", E_ACK);
        clr_in();
        cyc("end", E_NONE);

        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: STALL_CNT_W, default 16, width of the stall-cycle performance counter.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 id_p0_addr, id_p1_addr  in  4 each  source register addresses of the instruction in decode.
REQ-005 id_p0_used, id_p1_used  in  1 each  decode instruction reads that source.
REQ-006 ex_mem_re, ex_dst_addr  in  1 / 4  execute-stage instruction is a load, and its destination.
REQ-007 mispredict  in  1  branch resolved in execute disagrees with prediction.
REQ-008 send_pending, spart_full  in  1 / 1  send held in execute, and transmit queue full.
REQ-009 mem_wait  in  1  data memory not ready this cycle.
REQ-010 irq, irq_done  in  1 / 1  level interrupt request, and end-of-service pulse (return instruction retired).
REQ-011 stall_if, flush_if  out  1 / 1  hold the fetch/decode register, and replace fetched instruction with NOP.
REQ-012 stall_id, flush_id  out  1 / 1  hold the decode/execute register, and load a bubble into it.
REQ-013 stall_ex  out  1  hold the execute/memory register.
REQ-014 store_current, irq_ack  out  1 / 1  inject return-address save into decode/execute, and one-cycle interrupt acknowledge.
REQ-015 stall_cnt  out  STALL_CNT_W  saturating count of cycles with stall_if high.

Function
REQ-016 Hazard outputs SHALL be combinational from current inputs and state, valid in the same cycle.
REQ-017 Hazard priority, highest first: mem_wait, send block, mispredict, load-use, interrupt inject.
REQ-018 mem_wait=1 -> stall_if=stall_id=stall_ex=1; all flush and store_current outputs = 0.
REQ-019 Send block (send_pending & spart_full, no mem_wait) -> stall_if=stall_id=1, stall_ex=0.
REQ-020 mispredict, with no higher-priority condition -> flush_if=flush_id=1, all stalls 0.
REQ-021 Load-use: ex_mem_re & ex_dst_addr!=0 & ((id_p0_used & id_p0_addr==ex_dst_addr) | (id_p1_used & id_p1_addr==ex_dst_addr)) -> stall_if=1, flush_id=1, for exactly one cycle per hazard.
REQ-022 Register 0 SHALL never cause a load-use stall.
REQ-023 FSM states: RUN, IRQ_WAIT, IRQ_INJ, IRQ_SVC.
REQ-024 RUN -> IRQ_WAIT when irq=1.
REQ-025 IRQ_WAIT -> IRQ_INJ on the first cycle with no REQ-017 hazard active.
REQ-026 IRQ_INJ: store_current=1 for exactly one cycle; flush_if=1; next state IRQ_SVC.
REQ-027 A hazard arising during IRQ_INJ SHALL override per REQ-017, and the FSM SHALL return to IRQ_WAIT.
REQ-028 irq_ack SHALL be registered: high for one cycle, in the cycle after a completed IRQ_INJ.
REQ-029 IRQ_SVC ignores irq (no nesting); irq_done -> RUN.
REQ-030 irq_done outside IRQ_SVC SHALL be ignored.
REQ-031 irq deasserted while in IRQ_WAIT -> return to RUN with no injection.
REQ-032 stall_cnt increments each cycle with stall_if=1 and saturates at all-ones, with no wrap-around.

Reset
REQ-033 While rst_n=0: FSM = RUN, stall_cnt = 0, irq_ack = 0, and all stall, flush and store_current outputs = 0, irrespective of inputs.
REQ-034 Reset asserted mid-interrupt (any state) SHALL abandon the sequence; after release, a still-high irq restarts the sequence from RUN.

Structure
REQ-035 Shared package SHALL hold the FSM state encoding (2 bits), the hazard priority constants, and the NOP encoding 16'h0000.
REQ-036 Load-use comparator SHALL be one sub-module, hazard_detect, that is purely combinational.
REQ-037 FSM, irq_ack register and counter SHALL reside in pipe_ctrl.

Verification
REQ-038 Load r3 in execute, decode reads r3 on p1 -> one cycle of stall_if=1 and flush_id=1, then both 0; the same with r0 -> no stall.
REQ-039 mem_wait high for 3 cycles together with a load-use condition -> stall_if/id/ex=1 for 3 cycles with flush_id=0, then one load-use cycle.
REQ-040 irq raised while send_pending=spart_full=1 for 4 cycles -> store_current stays 0 until the block clears, then pulses once, followed by irq_ack one cycle later.
REQ-041 mispredict coincident with IRQ_INJ -> flush_if=flush_id=1, store_current=0, FSM back in IRQ_WAIT, injection on the next clean cycle.
REQ-042 Force 2^STALL_CNT_W+5 stall cycles -> stall_cnt holds all-ones.
REQ-043 rst_n low during IRQ_SVC with irq still high -> outputs 0; after release: RUN, IRQ_WAIT, IRQ_INJ in successive cycles.
